mmu_sequencer: RTL and testbench
================================

MMU_SEQUENCER -- requirements
Module: mmu_sequencer

Interface
REQ-001 SHALL have parameter RUN_CYCLES, default 6, number of compute cycles driven per job (legal range 1..8).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  job request, sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous job cancel.
REQ-006 SHALL have port load_valid  input  1  host byte valid.
REQ-007 SHALL have port load_data  input  8  host byte (4 weights, then 4 inputs).
REQ-008 SHALL have port load_ready  output  1  sequencer accepts a byte this cycle.
REQ-009 SHALL have ports weight_0..weight_3  output  8 each  latched weight operands.
REQ-010 SHALL have ports input_0..input_3  output  8 each  latched input operands.
REQ-011 SHALL have port mmu_en  output  1  feeder enable.
REQ-012 SHALL have port mmu_cycles  output  3  feeder phase index.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle job-complete pulse.

Function
REQ-015 SHALL implement states IDLE, LOAD_W, LOAD_X, RUN, DONE, with a 3-bit counter cnt.
REQ-016 IDLE: start=1 SHALL transition to LOAD_W with cnt=0 on the next edge; start SHALL be ignored in all other states.
REQ-017 load_ready SHALL equal (state is LOAD_W or LOAD_X) AND NOT abort, combinationally.
REQ-018 A beat SHALL be accepted only when load_valid AND load_ready are both high; load_valid low SHALL stall the load with no state change.
REQ-019 LOAD_W: the accepted beat SHALL write weight_[cnt] and increment cnt; the 4th beat SHALL transition to LOAD_X with cnt=0.
REQ-020 LOAD_X: the accepted beat SHALL write input_[cnt]; the 4th beat SHALL transition to RUN with cnt=0.
REQ-021 RUN: mmu_en SHALL be 1 and mmu_cycles SHALL equal cnt; cnt SHALL increment each cycle; the cycle with cnt=RUN_CYCLES-1 SHALL transition to DONE.
REQ-022 Outside RUN, mmu_en and mmu_cycles SHALL be 0.
REQ-023 DONE SHALL assert done for exactly one cycle, then transition to IDLE.
REQ-024 Latency: start edge to first mmu_en cycle = 1 + 8 beats; with back-to-back beats, RUN SHALL begin on the cycle after the 8th beat.
REQ-025 abort=1 in any state SHALL force IDLE with cnt=0 on the next edge; the beat in that cycle SHALL NOT be accepted; done SHALL NOT pulse.
REQ-026 abort SHALL take priority over start, over beat acceptance, and over the RUN-to-DONE transition.
REQ-027 Operand registers SHALL hold their values across jobs and across aborts; only accepted beats SHALL modify them.
REQ-028 Operand outputs SHALL be stable throughout RUN.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, cnt=0, and all operand registers to 0.
REQ-030 During reset, load_ready, mmu_en, mmu_cycles, busy and done SHALL all be 0.
REQ-031 Reset assertion mid-LOAD or mid-RUN SHALL discard the job; after release, a new start SHALL be required.

Configuration
REQ-032 Macro MMU_SEQ_WEIGHT_REUSE_EN defined: the block SHALL add port reuse_weights  input  1; when start and reuse_weights are both 1 in IDLE, the next state SHALL be LOAD_X, skipping LOAD_W and retaining the stored weights.
REQ-033 Macro MMU_SEQ_WEIGHT_REUSE_EN undefined: the reuse_weights port SHALL be absent, and every job SHALL load weights through LOAD_W.

Verification
REQ-034 Bench SHALL drive reset, start, 8 back-to-back beats 1..8 -> weight_0..3=1..4, input_0..3=5..8, mmu_cycles 0,1,2,3,4,5 with mmu_en=1, then one done pulse.
REQ-035 Bench SHALL deassert load_valid for 3 cycles after beat 2 -> weight_2 not written during the gap; RUN start delayed exactly 3 cycles.
REQ-036 Bench SHALL assert abort during RUN at mmu_cycles=3 -> IDLE next cycle; mmu_en=0; no done pulse; operands unchanged.
REQ-037 Bench SHALL assert abort together with a valid beat in LOAD_X -> beat rejected (load_ready=0); input register unchanged; busy=0 next cycle.
REQ-038 Bench SHALL assert start during RUN -> ignored; exactly one done pulse for the job.
REQ-039 With MMU_SEQ_WEIGHT_REUSE_EN defined, a second job with reuse_weights=1 and 4 beats 9..12 -> weights keep 1..4; inputs=9..12; RUN follows the 4th beat.

Source files
------------

// File: rtl/mmu_sequencer.sv
// mmu_sequencer
//   Job sequencer for a 4x4 matrix unit feeder. A job loads four weight bytes
//   and then four input bytes from a host byte stream. It then drives the
//   feeder for RUN_CYCLES compute cycles and pulses done.
//
//   Optional feature: define MMU_SEQ_WEIGHT_REUSE_EN to add reuse_weights.
//   A start with reuse_weights=1 skips the weight load and keeps the stored
//   weights.
//
// Ports
//   clk, rst_n            clock (rising edge); asynchronous active-low reset
//   start                 job request, sampled only when idle
//   abort                 synchronous cancel, highest priority
//   reuse_weights         (feature build only) skip the weight load phase
//   load_valid/load_data  host byte stream: 4 weights, then 4 inputs
//   load_ready            a byte is accepted this cycle when load_valid is also high
//   weight_0..3           latched weight operands
//   input_0..3            latched input operands
//   mmu_en, mmu_cycles    feeder enable and phase index (zero outside RUN)
//   busy                  high in every state except IDLE
//   done                  one-cycle job-complete pulse
module mmu_sequencer #(
    parameter int RUN_CYCLES = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
    input  logic       reuse_weights,
`endif
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic [7:0] weight_0,
    output logic [7:0] weight_1,
    output logic [7:0] weight_2,
    output logic [7:0] weight_3,
    output logic [7:0] input_0,
    output logic [7:0] input_1,
    output logic [7:0] input_2,
    output logic [7:0] input_3,
    output logic       mmu_en,
    output logic [2:0] mmu_cycles,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_X, S_RUN, S_DONE
    } state_t;

    localparam logic [2:0] LAST_RUN = 3'(RUN_CYCLES - 1);

    state_t          state, state_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic [3:0][7:0] weight_q, input_q;
    logic            beat;
    logic            reuse;

`ifdef MMU_SEQ_WEIGHT_REUSE_EN
    assign reuse = reuse_weights;
`else
    assign reuse = 1'b0;
`endif

    // abort is folded into load_ready, so a beat offered in the abort
    // cycle is never accepted.
    assign load_ready = ((state == S_LOAD_W) || (state == S_LOAD_X)) && !abort;
    assign beat       = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (abort) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 3'd0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state_nxt = reuse ? S_LOAD_X : S_LOAD_W;
                    cnt_nxt   = 3'd0;
                end
                S_LOAD_W: if (beat) begin
                    if (cnt == 3'd3) begin
                        state_nxt = S_LOAD_X;
                        cnt_nxt   = 3'd0;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                end
                S_LOAD_X: if (beat) begin
                    if (cnt == 3'd3) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = 3'd0;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                end
                S_RUN: begin
                    if (cnt == LAST_RUN) begin
                        state_nxt = S_DONE;
                        cnt_nxt   = 3'd0;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 3'd0;
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    // Operands change only on accepted beats. They are kept across jobs
    // and aborts so that weights can be reused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_q <= '0;
            input_q  <= '0;
        end else if (beat) begin
            if (state == S_LOAD_W) weight_q[cnt[1:0]] <= load_data;
            else                   input_q[cnt[1:0]]  <= load_data;
        end
    end

    assign weight_0   = weight_q[0];
    assign weight_1   = weight_q[1];
    assign weight_2   = weight_q[2];
    assign weight_3   = weight_q[3];
    assign input_0    = input_q[0];
    assign input_1    = input_q[1];
    assign input_2    = input_q[2];
    assign input_3    = input_q[3];
    assign mmu_en     = (state == S_RUN);
    assign mmu_cycles = (state == S_RUN) ? cnt : 3'd0;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
endmodule

// File: tb/tb_mmu_sequencer.sv
// tb_mmu_sequencer
//   Self-checking bench for mmu_sequencer. A job-level model tracks the
//   active flag, beats received (0..8), run index and operand arrays. A
//   negedge compare process checks every DUT output against that model
//   on every cycle. Directed scenarios add literal checks, and a random
//   phase follows.
module tb_mmu_sequencer;
    localparam int RC = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, load_valid = 1'b0, reuse_weights = 1'b0;
    logic [7:0] load_data = 8'd0;
    logic       load_ready, mmu_en, busy, done;
    logic [2:0] mmu_cycles;
    logic [7:0] weight_0, weight_1, weight_2, weight_3;
    logic [7:0] input_0, input_1, input_2, input_3;

    mmu_sequencer #(.RUN_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
        .reuse_weights(reuse_weights),
`endif
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .weight_0(weight_0), .weight_1(weight_1), .weight_2(weight_2), .weight_3(weight_3),
        .input_0(input_0), .input_1(input_1), .input_2(input_2), .input_3(input_3),
        .mmu_en(mmu_en), .mmu_cycles(mmu_cycles), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, done_cnt = 0, run_start_cyc = 0, start_cyc = 0;
    int run_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Job-level reference model.
    bit        m_act, m_done;
    int        m_beats, m_run;
    logic [7:0] m_w[4], m_x[4];
    bit        reuse_eff;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
    assign reuse_eff = reuse_weights;
`else
    assign reuse_eff = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_done = 0; m_beats = 0; m_run = 0;
            for (int i = 0; i < 4; i++) begin m_w[i] = 0; m_x[i] = 0; end
        end else if (abort) begin
            m_act = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_act) begin
            if (start) begin m_act = 1; m_beats = reuse_eff ? 4 : 0; m_run = 0; end
        end else if (m_beats < 8) begin
            if (load_valid) begin
                if (m_beats < 4) m_w[m_beats] = load_data;
                else             m_x[m_beats - 4] = load_data;
                m_beats++;
            end
        end else if (m_run == RC - 1) begin
            m_act = 0; m_done = 1;
        end else begin
            m_run++;
        end
    end

    always @(posedge clk) cyc++;

    // Per-cycle comparison against the model, plus observation records.
    always @(negedge clk) begin
        bit running;
        running = m_act && (m_beats == 8);
        chk("busy", busy, int'(m_act || m_done));
        chk("load_ready", load_ready, int'(m_act && m_beats < 8 && !abort));
        chk("mmu_en", mmu_en, int'(running));
        chk("mmu_cycles", mmu_cycles, running ? m_run : 0);
        chk("done", done, int'(m_done));
        chk("weight_0", weight_0, m_w[0]); chk("weight_1", weight_1, m_w[1]);
        chk("weight_2", weight_2, m_w[2]); chk("weight_3", weight_3, m_w[3]);
        chk("input_0", input_0, m_x[0]);   chk("input_1", input_1, m_x[1]);
        chk("input_2", input_2, m_x[2]);   chk("input_3", input_3, m_x[3]);
        if (done) done_cnt++;
        if (mmu_en) run_q.push_back(int'(mmu_cycles));
        if (mmu_en && mmu_cycles == 3'd0) run_start_cyc = cyc;
    end

    task automatic tick; @(posedge clk); #1; endtask
    task automatic do_start(input bit ru);
        start = 1; reuse_weights = ru; start_cyc = cyc; tick; start = 0; reuse_weights = 0;
    endtask
    task automatic beat(input int d);
        load_valid = 1; load_data = 8'(d); tick; load_valid = 0;
    endtask
    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 40) begin tick; n++; end
        chk("done_timeout", int'(done_cnt > base), 1);
    endtask

    initial begin
        int base;
        repeat (3) tick;
        chk("rst_busy", busy, 0); chk("rst_ready", load_ready, 0);
        chk("rst_en", mmu_en, 0); chk("rst_weight_0", weight_0, 0);
        rst_n = 1; tick;

        // Basic job: beats 1..8, RUN phases 0..5, one done pulse.
        base = done_cnt; run_q.delete();
        do_start(0);
        for (int i = 1; i <= 8; i++) beat(i);
        wait_done(base); tick;
        chk("j1_w0", weight_0, 1); chk("j1_w3", weight_3, 4);
        chk("j1_x0", input_0, 5);  chk("j1_x3", input_3, 8);
        chk("j1_run_len", run_q.size(), RC);
        for (int i = 0; i < RC && i < run_q.size(); i++) chk("j1_run_seq", run_q[i], i);
        chk("j1_latency", run_start_cyc - start_cyc, 9);
        chk("j1_done_pulses", done_cnt - base, 1);

        // A 3-cycle valid gap after beat 2 delays RUN by exactly 3 cycles.
        base = done_cnt;
        do_start(0);
        beat(11); beat(12);
        load_data = 8'hEE; repeat (3) tick;
        chk("gap_w2_held", weight_2, 3);
        for (int i = 13; i <= 18; i++) beat(i);
        wait_done(base);
        chk("gap_latency", run_start_cyc - start_cyc, 12);
        chk("gap_w2_new", weight_2, 13);

        // Abort in RUN at phase 3.
        do_start(0);
        for (int i = 21; i <= 28; i++) beat(i);
        repeat (3) tick;
        chk("ab_phase", mmu_cycles, 3);
        abort = 1; tick; abort = 0;
        chk("ab_busy", busy, 0); chk("ab_en", mmu_en, 0);
        base = done_cnt; repeat (5) tick;
        chk("ab_no_done", done_cnt - base, 0);
        chk("ab_w0", weight_0, 21); chk("ab_x3", input_3, 28);

        // Abort together with a valid beat in LOAD_X.
        do_start(0);
        for (int i = 31; i <= 34; i++) beat(i);
        load_valid = 1; load_data = 8'd99; abort = 1; #1;
        chk("abx_ready", load_ready, 0);
        tick; abort = 0; load_valid = 0;
        chk("abx_busy", busy, 0); chk("abx_x0", input_0, 25);

        // start held during RUN is ignored.
        base = done_cnt;
        do_start(0);
        for (int i = 41; i <= 48; i++) beat(i);
        start = 1; repeat (2) tick; start = 0;
        wait_done(base); repeat (4) tick;
        chk("sr_done_pulses", done_cnt - base, 1);
        chk("sr_busy", busy, 0);

        // Reset mid-RUN discards the job and clears operands.
        do_start(0);
        for (int i = 51; i <= 58; i++) beat(i);
        tick; rst_n = 0; #1;
        chk("mr_w0", weight_0, 0); chk("mr_busy", busy, 0); chk("mr_en", mmu_en, 0);
        tick; rst_n = 1; repeat (3) tick;
        chk("mr_idle", busy, 0);

`ifdef MMU_SEQ_WEIGHT_REUSE_EN
        base = done_cnt;
        do_start(0);
        for (int i = 1; i <= 8; i++) beat(i);
        wait_done(base); tick;
        base = done_cnt;
        do_start(1);
        for (int i = 9; i <= 12; i++) beat(i);
        chk("ru_run", mmu_en, 1);
        wait_done(base);
        chk("ru_w0", weight_0, 1); chk("ru_w3", weight_3, 4);
        chk("ru_x0", input_0, 9);  chk("ru_x3", input_3, 12);
`endif

        // Random phase, checked cycle by cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            start         = ($urandom % 4) == 0;
            abort         = ($urandom % 40) == 0;
            load_valid    = $urandom % 2;
            load_data     = 8'($urandom);
            reuse_weights = $urandom % 2;
            tick;
        end
        start = 0; abort = 0; load_valid = 0; reuse_weights = 0;
        repeat (20) tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
